// File: rtl/camera_capture.sv
// camera_capture: DVP-style camera byte stream to pixel stream.
//
// Registers href/vsync/camData once on pclk. A small FSM locks onto the
// vertical sync pulse, then assembles BYTES_PER_PIXEL bytes per pixel. It
// emits one strobe per in-window pixel with its coordinates, and reports
// on every frame close whether that frame had the expected geometry.
//
// Parameters:
//   WIDTH            active pixels per line
//   HEIGHT           active lines per frame
//   BYTES_PER_PIXEL  1 or 2 camData bytes per pixel
//
// Ports:
//   pclk        capture clock (rising edge)
//   reset       asynchronous active-high reset
//   href        high while line bytes are on camData
//   vsync       low during vertical sync pulse
//   camData     pixel byte
//   pixelValid  one-cycle pixel strobe
//   pixelData   assembled pixel (first byte high when 2 bytes per pixel)
//   pixelX/Y    pixel coordinates
//   frameStart  set with the strobe of pixel (0,0)
//   frameEnd    one-cycle pulse when a captured frame closes
//   frameErr    valid with frameEnd: closed frame was malformed
//
// Optional build macro CAMERA_CAPTURE_STATS_EN adds:
//   frameCount  frames closed (wrapping)
//   errCount    frames closed with frameErr (saturating)
module camera_capture #(
  parameter int WIDTH           = 1280,
  parameter int HEIGHT          = 800,
  parameter int BYTES_PER_PIXEL = 2
) (
  input  logic                      pclk,
  input  logic                      reset,
  input  logic                      href,
  input  logic                      vsync,
  input  logic [7:0]                camData,
  output logic                      pixelValid,
  output logic [15:0]               pixelData,
  output logic [$clog2(WIDTH)-1:0]  pixelX,
  output logic [$clog2(HEIGHT)-1:0] pixelY,
  output logic                      frameStart,
  output logic                      frameEnd,
  output logic                      frameErr
`ifdef CAMERA_CAPTURE_STATS_EN
  ,
  output logic [15:0]               frameCount,
  output logic [15:0]               errCount
`endif
);

  localparam int XW         = $clog2(WIDTH);
  localparam int YW         = $clog2(HEIGHT);
  localparam int LINE_BYTES = WIDTH * BYTES_PER_PIXEL;
  // Counters are one step wider than the coordinates so they can sit past
  // the active window (saturated) and still be told apart from a full line.
  localparam int XCW        = $clog2(WIDTH + 1);
  localparam int YCW        = $clog2(HEIGHT + 2);
  localparam int BCW        = $clog2(LINE_BYTES + 2);

  typedef enum logic [1:0] {UNSYNCED, SYNC, FRAME} state_t;

  state_t state_reg, state_next;

  // Input stage plus one delayed copy of the controls for edge detection.
  logic       href_reg, vsync_reg, href_d_reg, vsync_d_reg;
  logic [7:0] data_reg;

  logic [XCW-1:0] x_cnt_reg, x_cnt_next;
  logic [YCW-1:0] y_cnt_reg, y_cnt_next;
  logic [BCW-1:0] byte_cnt_reg, byte_cnt_next;
  logic           phase_reg, phase_next;
  logic [7:0]     hi_reg, hi_next;
  logic           err_reg, err_next;

  logic          valid_reg, valid_next;
  logic [15:0]   pdata_reg, pdata_next;
  logic [XW-1:0] px_reg, px_next;
  logic [YW-1:0] py_reg, py_next;
  logic          start_reg, start_next;
  logic          end_reg, end_next;
  logic          ferr_reg, ferr_next;

  logic        line_end, vsync_fall, vsync_rise;
  logic        pixel_done;
  logic [15:0] pixel_word;

  assign line_end   = href_d_reg & ~href_reg;
  assign vsync_fall = vsync_d_reg & ~vsync_reg;
  assign vsync_rise = ~vsync_d_reg & vsync_reg;

  generate
    if (BYTES_PER_PIXEL == 1) begin : g_bpp1
      assign pixel_done = href_reg;
      assign pixel_word = {8'h00, data_reg};
    end else begin : g_bpp2
      assign pixel_done = href_reg & phase_reg;
      assign pixel_word = {hi_reg, data_reg};
    end
  endgenerate

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      href_reg    <= 1'b0;
      vsync_reg   <= 1'b1;
      data_reg    <= 8'h00;
      href_d_reg  <= 1'b0;
      vsync_d_reg <= 1'b1;
    end else begin
      href_reg    <= href;
      vsync_reg   <= vsync;
      data_reg    <= camData;
      href_d_reg  <= href_reg;
      vsync_d_reg <= vsync_reg;
    end
  end

  // A vsync falling edge always resynchronises, whatever the state.
  always_comb begin
    state_next = state_reg;
    if (vsync_fall) begin
      state_next = SYNC;
    end else if (state_reg == SYNC && vsync_rise) begin
      state_next = FRAME;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state_reg <= UNSYNCED;
    else       state_reg <= state_next;
  end

  always_comb begin
    x_cnt_next    = x_cnt_reg;
    y_cnt_next    = y_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    phase_next    = phase_reg;
    hi_next       = hi_reg;
    err_next      = err_reg;
    valid_next    = 1'b0;
    pdata_next    = pdata_reg;
    px_next       = px_reg;
    py_next       = py_reg;
    start_next    = 1'b0;
    end_next      = 1'b0;
    ferr_next     = 1'b0;
    if (state_reg != FRAME) begin
      // Outside a frame everything is held clear, so FRAME starts at (0,0).
      x_cnt_next    = '0;
      y_cnt_next    = '0;
      byte_cnt_next = '0;
      phase_next    = 1'b0;
      err_next      = 1'b0;
    end else begin
      if (href_reg) begin
        if (byte_cnt_reg != BCW'(LINE_BYTES + 1)) byte_cnt_next = byte_cnt_reg + BCW'(1);
        if (pixel_done) begin
          phase_next = 1'b0;
          if (x_cnt_reg < XCW'(WIDTH) && y_cnt_reg < YCW'(HEIGHT)) begin
            valid_next = 1'b1;
            pdata_next = pixel_word;
            px_next    = x_cnt_reg[XW-1:0];
            py_next    = y_cnt_reg[YW-1:0];
            start_next = (x_cnt_reg == '0) && (y_cnt_reg == '0);
          end
          if (x_cnt_reg != XCW'(WIDTH)) x_cnt_next = x_cnt_reg + XCW'(1);
        end else begin
          phase_next = 1'b1;
          hi_next    = data_reg;
        end
      end
      if (line_end) begin
        // A half-assembled pixel is dropped here and taints the frame.
        if (phase_reg || byte_cnt_reg != BCW'(LINE_BYTES)) err_next = 1'b1;
        x_cnt_next    = '0;
        byte_cnt_next = '0;
        phase_next    = 1'b0;
        if (y_cnt_reg != YCW'(HEIGHT + 1)) y_cnt_next = y_cnt_reg + YCW'(1);
      end
      // Uses the *_next values so a line closing on this same edge counts.
      if (vsync_fall) begin
        end_next  = 1'b1;
        ferr_next = err_next | (y_cnt_next != YCW'(HEIGHT));
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      x_cnt_reg    <= '0;
      y_cnt_reg    <= '0;
      byte_cnt_reg <= '0;
      phase_reg    <= 1'b0;
      hi_reg       <= 8'h00;
      err_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      pdata_reg    <= 16'h0000;
      px_reg       <= '0;
      py_reg       <= '0;
      start_reg    <= 1'b0;
      end_reg      <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      x_cnt_reg    <= x_cnt_next;
      y_cnt_reg    <= y_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      phase_reg    <= phase_next;
      hi_reg       <= hi_next;
      err_reg      <= err_next;
      valid_reg    <= valid_next;
      pdata_reg    <= pdata_next;
      px_reg       <= px_next;
      py_reg       <= py_next;
      start_reg    <= start_next;
      end_reg      <= end_next;
      ferr_reg     <= ferr_next;
    end
  end

  assign pixelValid = valid_reg;
  assign pixelData  = pdata_reg;
  assign pixelX     = px_reg;
  assign pixelY     = py_reg;
  assign frameStart = start_reg;
  assign frameEnd   = end_reg;
  assign frameErr   = ferr_reg;

`ifdef CAMERA_CAPTURE_STATS_EN
  logic [15:0] frame_count_reg, err_count_reg;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      frame_count_reg <= 16'h0000;
      err_count_reg   <= 16'h0000;
    end else if (end_reg) begin
      frame_count_reg <= frame_count_reg + 16'd1;
      if (ferr_reg && err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign frameCount = frame_count_reg;
  assign errCount   = err_count_reg;
`else
`endif

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with WIDTH=8, HEIGHT=4, 2 bytes/pixel.
// A negedge monitor keeps running totals of DUT strobes. The single
// stimulus sequence snapshots those totals around each scenario and
// compares the differences to hand-computed values.
module tb_camera_capture;
  logic        pclk;
  logic        reset;
  logic        href;
  logic        vsync;
  logic [7:0]  camData;
  logic        pixelValid;
  logic [15:0] pixelData;
  logic [2:0]  pixelX;
  logic [1:0]  pixelY;
  logic        frameStart;
  logic        frameEnd;
  logic        frameErr;
`ifdef CAMERA_CAPTURE_STATS_EN
  logic [15:0] frameCount;
  logic [15:0] errCount;
`endif

  camera_capture #(.WIDTH(8), .HEIGHT(4), .BYTES_PER_PIXEL(2)) dut (
    .pclk(pclk),
    .reset(reset),
    .href(href),
    .vsync(vsync),
    .camData(camData),
    .pixelValid(pixelValid),
    .pixelData(pixelData),
    .pixelX(pixelX),
    .pixelY(pixelY),
    .frameStart(frameStart),
    .frameEnd(frameEnd),
    .frameErr(frameErr)
`ifdef CAMERA_CAPTURE_STATS_EN
    ,
    .frameCount(frameCount),
    .errCount(errCount)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Monitor totals (written only by the monitor).
  int          pix_total = 0;
  int          start_total = 0;
  int          end_total = 0;
  int          mism_total = 0;
  logic [15:0] last_data = '0;
  logic [2:0]  last_x = '0;
  logic [1:0]  last_y = '0;
  logic [15:0] start_data = '0;
  logic [2:0]  start_x = '0;
  logic [1:0]  start_y = '0;
  logic        last_err = 1'b0;
  logic        clean_mode = 1'b0;

  // Snapshots taken by the stimulus block.
  int base_pix, base_start, base_end, base_mism;

  // In a clean frame the bytes run 0,1,2,... so pixel (x,y) is {2n, 2n+1}.
  function automatic logic [15:0] clean_word(input int x, input int y);
    int b;
    b = 2 * (y * 8 + x);
    return {8'(b), 8'(b + 1)};
  endfunction

  always @(negedge pclk) begin
    if (pixelValid) begin
      pix_total <= pix_total + 1;
      last_data <= pixelData;
      last_x    <= pixelX;
      last_y    <= pixelY;
      if (clean_mode && pixelData !== clean_word(int'(pixelX), int'(pixelY)))
        mism_total <= mism_total + 1;
    end
    if (frameStart) begin
      start_total <= start_total + 1;
      start_data  <= pixelData;
      start_x     <= pixelX;
      start_y     <= pixelY;
    end
    if (frameEnd) begin
      end_total <= end_total + 1;
      last_err  <= frameErr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic h, input logic v, input logic [7:0] d);
    @(negedge pclk);
    href    = h;
    vsync   = v;
    camData = d;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b1, 8'h00);
    @(negedge pclk);
    #1;
  endtask

  // Vertical sync pulse: closes the current frame and opens the next.
  task automatic vpulse();
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b1, 8'h00);
  endtask

  // nlines lines of nbytes, except line short_line which gets short_bytes.
  // With merge set the last line's href drop is left to the following vpulse.
  task automatic send_lines(input int nlines, input int nbytes, input int short_line,
                            input int short_bytes, input bit merge);
    int b;
    int n;
    b = 0;
    for (int l = 0; l < nlines; l++) begin
      n = (l == short_line) ? short_bytes : nbytes;
      for (int i = 0; i < n; i++) begin
        cyc(1'b1, 1'b1, 8'(b));
        b++;
      end
      if (!(merge && l == nlines - 1)) repeat (3) cyc(1'b0, 1'b1, 8'h00);
    end
  endtask

  task automatic snap();
    base_pix   = pix_total;
    base_start = start_total;
    base_end   = end_total;
    base_mism  = mism_total;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(pixelValid), 32'd0);
    check({tag, "_data"},  32'(pixelData),  32'd0);
    check({tag, "_x"},     32'(pixelX),     32'd0);
    check({tag, "_y"},     32'(pixelY),     32'd0);
    check({tag, "_start"}, 32'(frameStart), 32'd0);
    check({tag, "_end"},   32'(frameEnd),   32'd0);
    check({tag, "_err"},   32'(frameErr),   32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    href    = 1'b0;
    vsync   = 1'b1;
    camData = 8'h00;
    repeat (3) @(negedge pclk);
    #1;
    check_outputs_zero("reset");
    @(negedge pclk);
    reset = 1'b0;

    // Lines before any vsync pulse are ignored; the first pulse closes nothing.
    snap();
    send_lines(2, 16, -1, 0, 1'b0);
    vpulse();
    idle(4);
    check("unsync_pix", 32'(pix_total - base_pix), 32'd0);
    check("unsync_end", 32'(end_total - base_end), 32'd0);

    // Clean frame of bytes 0x00..0x3F.
    clean_mode = 1'b1;
    snap();
    send_lines(4, 16, -1, 0, 1'b0);
    vpulse();
    idle(4);
    check("clean_pix",    32'(pix_total - base_pix),     32'd32);
    check("clean_starts", 32'(start_total - base_start), 32'd1);
    check("clean_sdata",  32'(start_data), 32'h0001);
    check("clean_sx",     32'(start_x),    32'd0);
    check("clean_sy",     32'(start_y),    32'd0);
    check("clean_ldata",  32'(last_data),  32'h3E3F);
    check("clean_lx",     32'(last_x),     32'd7);
    check("clean_ly",     32'(last_y),     32'd3);
    check("clean_ends",   32'(end_total - base_end),     32'd1);
    check("clean_err",    32'(last_err),   32'd0);
    check("clean_mism",   32'(mism_total - base_mism),   32'd0);

    // Line 1 carries 15 bytes: 7 pixels there, trailing byte discarded.
    clean_mode = 1'b0;
    snap();
    send_lines(4, 16, 1, 15, 1'b0);
    vpulse();
    idle(4);
    check("short_pix",  32'(pix_total - base_pix), 32'd31);
    check("short_ends", 32'(end_total - base_end), 32'd1);
    check("short_err",  32'(last_err), 32'd1);

    // 5 lines of 10 pixels: only the 8x4 window is strobed.
    snap();
    send_lines(5, 20, -1, 0, 1'b0);
    vpulse();
    idle(4);
    check("over_pix",   32'(pix_total - base_pix), 32'd32);
    check("over_ldata", 32'(last_data), 32'h4A4B);
    check("over_lx",    32'(last_x), 32'd7);
    check("over_ly",    32'(last_y), 32'd3);
    check("over_ends",  32'(end_total - base_end), 32'd1);
    check("over_err",   32'(last_err), 32'd1);

    // Last href drop coincides with vsync fall: line closes before the frame.
    clean_mode = 1'b1;
    snap();
    send_lines(4, 16, -1, 0, 1'b1);
    vpulse();
    idle(4);
    check("merge_pix",  32'(pix_total - base_pix), 32'd32);
    check("merge_ends", 32'(end_total - base_end), 32'd1);
    check("merge_err",  32'(last_err), 32'd0);
    check("merge_mism", 32'(mism_total - base_mism), 32'd0);

    // Reset in the middle of line 2: outputs clear, frame abandoned silently.
    snap();
    send_lines(2, 16, -1, 0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'(32 + i));
    @(negedge pclk);
    reset   = 1'b1;
    href    = 1'b0;
    camData = 8'h00;
    @(negedge pclk);
    #1;
    check_outputs_zero("midrst");
    @(negedge pclk);
    reset = 1'b0;
    idle(6);
    check("midrst_ends", 32'(end_total - base_end), 32'd0);
    snap();
    vpulse();
    send_lines(4, 16, -1, 0, 1'b0);
    vpulse();
    idle(4);
    check("after_pix",  32'(pix_total - base_pix), 32'd32);
    check("after_ends", 32'(end_total - base_end), 32'd1);
    check("after_err",  32'(last_err), 32'd0);
    check("after_mism", 32'(mism_total - base_mism), 32'd0);

`ifdef CAMERA_CAPTURE_STATS_EN
    // Three frames, the middle one malformed.
    @(negedge pclk);
    reset = 1'b1;
    @(negedge pclk);
    #1;
    check("stats_rst_frames", 32'(frameCount), 32'd0);
    check("stats_rst_errs",   32'(errCount),   32'd0);
    reset = 1'b0;
    clean_mode = 1'b0;
    vpulse();
    send_lines(4, 16, -1, 0, 1'b0);
    vpulse();
    send_lines(4, 16, 2, 15, 1'b0);
    vpulse();
    send_lines(4, 16, -1, 0, 1'b0);
    vpulse();
    idle(4);
    check("stats_frames", 32'(frameCount), 32'd3);
    check("stats_errs",   32'(errCount),   32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
